div_sequencer: RTL and testbench

Multi-cycle integer divide unit for the RV-i16 execute stage. Accepts one divide/remainder request at a time through a start/busy/done handshake and computes it with a restoring shift-subtract loop, one quotient bit per clock. Signed operands are handled by sign/magnitude conversion around an unsigned core. Divide-by-zero and signed overflow follow RISC-V M-extension semantics. It replaces the combinational divider on the ALU's critical path.

---
 rtl/div_if.sv | 25 ++
 rtl/div_sequencer.sv | 139 +++++++++++++
 tb/tb_div_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the multi-cycle divider.
// start is sampled only while busy=0; done is a one-cycle pulse with busy=0 that qualifies result/div_by_zero.
interface div_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/div_sequencer.sv
// Restoring shift-subtract divider, one quotient bit per clock.
// Signed ops run on magnitudes; signs are reapplied in the FIX state.
module div_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  div_if.slave       bus,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic             accept;
  logic             last_iter;

  logic             is_rem_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic             zero_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [RW-1:0]    rem_q;
  logic [CW-1:0]    cnt_q;

  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             dbz_q;

  logic             signed_op;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [RW:0]      rem_sh;
  logic             ge;
  logic [WIDTH-1:0] fix_result;

  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Flush wins over start, and is the only way out of ITER before the last bit.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          accept  = 1'b1;
          state_n = (bus.b == '0) ? FIX : ITER;
        end
      end
      ITER: begin
        if (bus.flush)      state_n = IDLE;
        else if (last_iter) state_n = FIX;
      end
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    signed_op = ~bus.op[0];
    a_mag     = (signed_op && bus.a[WIDTH-1]) ? ('0 - bus.a) : bus.a;
    b_mag     = (signed_op && bus.b[WIDTH-1]) ? ('0 - bus.b) : bus.b;
    rem_sh    = {rem_q, dvd_q[WIDTH-1]};
    ge        = (rem_sh >= {2'b00, dvs_q});
  end

  // With a zero divisor the dividend magnitude is still in dvd_q, so
  // reapplying A's sign reproduces A exactly for the remainder ops.
  always_comb begin
    fix_result = '1;
    if (zero_q) begin
      if (is_rem_q) fix_result = sign_a_q ? ('0 - dvd_q) : dvd_q;
    end else if (is_rem_q) begin
      fix_result = sign_a_q ? ('0 - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
    end else begin
      fix_result = (sign_a_q ^ sign_b_q) ? ('0 - dvd_q) : dvd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_rem_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      zero_q   <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      is_rem_q <= bus.op[1];
      sign_a_q <= signed_op & bus.a[WIDTH-1];
      sign_b_q <= signed_op & bus.b[WIDTH-1];
      zero_q   <= (bus.b == '0);
      dvd_q    <= a_mag;
      dvs_q    <= b_mag;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else if (state == ITER) begin
      dvd_q <= {dvd_q[WIDTH-2:0], ge};
      rem_q <= ge ? RW'(rem_sh - {2'b00, dvs_q}) : RW'(rem_sh);
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= (state == FIX) && !bus.flush;
      if ((state == FIX) && !bus.flush) begin
        result_q <= fix_result;
        dbz_q    <= zero_q;
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: hand-computed vectors, latency, ignored start, flush and reset abort.
module tb_div_sequencer;
  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  div_if #(.WIDTH(W)) bus ();

  div_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is presented for the following posedge (accept edge).
  task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_res,
                       input logic exp_dbz, input int exp_lat);
    int lat;
    logic [W-1:0] exp_v;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    exp_q.push_back(exp_res);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom_range(0, 65535));
    bus.b     = W'($urandom_range(0, 65535));
    bus.op    = 2'($urandom_range(0, 3));
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    exp_v = exp_q.pop_front();
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, 32'(bus.result), 32'(exp_v));
    check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(exp_dbz));
    check({tag, "_busy_on_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int lat;
    int done_seen;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;

    // Reset values while rst_n is held low
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_res", 32'(bus.result), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: each op is started in the Done cycle of the previous one
    do_op("divu_18_4",  2'b01, 16'd18,   16'd4,      16'd4,      1'b0, 17);
    do_op("remu_18_5",  2'b11, 16'd18,   16'd5,      16'd3,      1'b0, 17);
    do_op("div_m7_2",   2'b00, 16'hFFF9, 16'd2,      16'hFFFD,   1'b0, 17);
    do_op("rem_m7_2",   2'b10, 16'hFFF9, 16'd2,      16'hFFFF,   1'b0, 17);
    do_op("div_7_m2",   2'b00, 16'd7,    16'hFFFE,   16'hFFFD,   1'b0, 17);
    do_op("rem_7_m2",   2'b10, 16'd7,    16'hFFFE,   16'h0001,   1'b0, 17);
    do_op("divu_7_0",   2'b01, 16'd7,    16'd0,      16'hFFFF,   1'b1, 1);
    do_op("rem_7_0",    2'b10, 16'd7,    16'd0,      16'd7,      1'b1, 1);
    do_op("divu_5_2",   2'b01, 16'd5,    16'd2,      16'd2,      1'b0, 17);
    do_op("div_ovf",    2'b00, 16'h8000, 16'hFFFF,   16'h8000,   1'b0, 17);
    do_op("rem_ovf",    2'b10, 16'h8000, 16'hFFFF,   16'h0000,   1'b0, 17);
    do_op("rem_m7_0",   2'b10, 16'hFFF9, 16'd0,      16'hFFF9,   1'b1, 1);
    do_op("div_min_0",  2'b00, 16'h8000, 16'd0,      16'hFFFF,   1'b1, 1);
    do_op("divu_max_1", 2'b01, 16'hFFFF, 16'd1,      16'hFFFF,   1'b0, 17);
    do_op("remu_max",   2'b11, 16'hFFFF, 16'h00FF,   16'h0000,   1'b0, 17);
    @(negedge clk);
    check("done_drops", 32'(bus.done), 32'd0);
    check("idle_after", 32'(bus.busy), 32'd0);

    // Start pulses while busy must be ignored
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 16'd100;
    bus.b     = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (lat == 3 || lat == 10) begin
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 16'd9;
        bus.b     = 16'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check("ign_lat", 32'(lat), 32'd17);
    check("ign_res", 32'(bus.result), 32'd14);
    check("ign_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    check("ign_noqueue", 32'(bus.busy), 32'd0);

    // Flush during iteration 8
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 16'd1000;
    bus.b     = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("fl_busy_before", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("fl_busy", 32'(bus.busy), 32'd0);
    check("fl_state", 32'(dbg_state), 32'd0);
    check("fl_res_held", 32'(bus.result), 32'd14);
    check("fl_dbz_held", 32'(bus.div_by_zero), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    check("fl_no_done", 32'(done_seen), 32'd0);

    // Asynchronous reset in the middle of ITER
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 16'hFFF9;
    bus.b     = 16'd2;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", 32'(bus.busy), 32'd0);
    check("ar_done", 32'(bus.done), 32'd0);
    check("ar_res", 32'(bus.result), 32'd0);
    check("ar_dbz", 32'(bus.div_by_zero), 32'd0);
    check("ar_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("post_rst", 2'b01, 16'd5, 16'd2, 16'd2, 1'b0, 17);
    check("scb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
